decode_top: RTL and testbench
=============================

# decode_top

Decode stage of the in-order core, directly downstream of the fetch stage. It accepts one instruction per cycle and cracks it into opcode, register and immediate fields. It reads the 32-entry register file, with bypass from the writeback port, and tracks in-flight destinations with a scoreboard. It presents a registered, decoded instruction to the ALU stage and applies back-pressure to fetch.

## Interface
- `REG_NUM`, 32: architectural registers; index width `REG_ADDR_WIDTH` = 5.
- `DATA_WIDTH`, 32: register and immediate width.
- `clock` in 1: single core clock.
- `reset` in 1: asynchronous, active-high.
- `decode_instr_valid` in 1: fetched instruction valid.
- `decode_instr_data` in `INSTR_WIDTH` (32): instruction word.
- `decode_instr_pc` in `PC_WIDTH`: PC of the instruction.
- `stall_fetch` out 1: fetch must hold; combinational.
- `stall_decode` in 1: ALU stage cannot accept.
- `flush` in 1: branch taken downstream; kill decode contents.
- `wb_valid` in 1, `wb_dest` in 5, `wb_data` in 32: register write.
- `alu_instr_valid` out 1, `alu_opcode` out 7, `alu_rd` out 5, `alu_ra_data` out 32, `alu_rb_data` out 32, `alu_offset` out 32, `alu_pc` out `PC_WIDTH`: registered decoded instruction.
- `decode_illegal` out 1: registered pulse, unknown opcode.

## Operation
- Format: opcode [31:25], rd [24:20], ra [19:15], rb [14:10], offset [14:0] sign-extended to 32 bits.
- Opcodes:
  - ADD 0x00, SUB 0x01, MUL 0x02: R-type; read ra and rb, write rd.
  - LDB 0x10, LDW 0x11: read ra, write rd.
  - STB 0x12, STW 0x13: read ra (base) and rb (data); no write.
  - BEQ 0x30: read ra and rb; no write.
  - JUMP 0x31: read ra; no write.
  - Any other opcode: illegal; issues as a bubble and pulses `decode_illegal`.
- Skid buffer, one entry: captures the input instruction when it is valid and the stage cannot advance.
- Decode source: the skid buffer if occupied, otherwise the live input.
- Register file: 32×32 flops. Write on `wb_valid`. A read of a register written in the same cycle returns `wb_data` (bypass).
- Scoreboard: one pending bit per register.
  - Set on issue of any writing instruction to its rd.
  - Cleared on `wb_valid` for `wb_dest`.
  - Set and clear in the same cycle on the same register: set wins.
- Hazard: stall if any used source, or rd, is pending and not cleared by a writeback this cycle. rd is checked to prevent WAW.
- Advance condition: source valid, no hazard, `!stall_decode`.
  - On advance: load the output registers and set `alu_instr_valid` = 1.
  - Otherwise: `alu_instr_valid` = 0 if `!stall_decode`; hold all outputs if `stall_decode`.
- `stall_fetch` = skid buffer occupied or (input valid and not advancing).
- Flush:
  - Clears the skid buffer, `alu_instr_valid` and the whole scoreboard.
  - Downstream contract: every older instruction has written back before `flush` is asserted.
  - Writebacks arriving with flush still update the register file.

## Timing
- Reset values: all outputs 0, scoreboard 0, skid buffer empty, register file 0.
- Latency: input at cycle N → `alu_*` valid at N+1 when no hazard or stall.
- Throughput: one instruction per cycle without hazards.
- Writeback in cycle N makes a dependent instruction issue in cycle N (via bypass).
- `flush` has priority over advance and over `stall_decode`.
- Reset asserted mid-operation clears state immediately (asynchronous).

## Structure
- Shared package `core_pkg`: opcode localparams, field bit-position constants, `REG_ADDR_WIDTH`, and a `decoded_instr_t` struct (opcode, rd, ra, rb, offset, pc, uses_ra, uses_rb, writes_rd).
- Sub-module `reg_file`: 32×32 array with async reset, two combinational read ports, one write port and the write-to-read bypass.
- `decode_top` holds the field decode, scoreboard, skid buffer and output registers.

## Test plan
- Reset, then ADD r3=r1+r2 with wb preloading r1=5 and r2=7 → next cycle `alu_instr_valid`=1, ra_data=5, rb_data=7, rd=3; scoreboard[3]=1.
- ADD r3 immediately followed by SUB r4=r3-r1 → `stall_fetch`=1 until wb r3=12 arrives; SUB issues in the wb cycle with ra_data=12.
- `stall_decode` held 3 cycles while a second instruction arrives → skid buffer captures it and outputs hold; on release both issue in order on consecutive cycles.
- LDW r5 with offset 0x7FFC → `alu_offset`=0xFFFFFFFC.
- Opcode 0x7F → `decode_illegal` pulse, `alu_instr_valid`=0.
- `flush` while the skid buffer is occupied and r3 is pending → buffer empty, `alu_instr_valid`=0, scoreboard 0, `stall_fetch`=0 next cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared decode-stage definitions: instruction field positions, opcodes and
// the decoded-instruction record passed between decode logic and outputs.
package core_pkg;
  localparam int REG_NUM        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int DATA_WIDTH     = 32;
  localparam int INSTR_WIDTH    = 32;
  localparam int PC_WIDTH       = 32;
  localparam int OPCODE_WIDTH   = 7;

  localparam int OPC_MSB = 31, OPC_LSB = 25;
  localparam int RD_MSB  = 24, RD_LSB  = 20;
  localparam int RA_MSB  = 19, RA_LSB  = 15;
  localparam int RB_MSB  = 14, RB_LSB  = 10;
  localparam int OFF_MSB = 14, OFF_LSB = 0;
  localparam int OFF_WIDTH = OFF_MSB - OFF_LSB + 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 7'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 7'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = 7'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB  = 7'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW  = 7'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB  = 7'h12;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW  = 7'h13;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 7'h30;
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP = 7'h31;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [REG_ADDR_WIDTH-1:0] rb;
    logic [DATA_WIDTH-1:0]     offset;
    logic [PC_WIDTH-1:0]       pc;
    logic                      uses_ra;
    logic                      uses_rb;
    logic                      writes_rd;
    logic                      legal;
  } decoded_instr_t;

  function automatic decoded_instr_t decode_instr(input logic [INSTR_WIDTH-1:0] instr,
                                                  input logic [PC_WIDTH-1:0] pc);
    decoded_instr_t d;
    d        = '0;
    d.opcode = instr[OPC_MSB:OPC_LSB];
    d.rd     = instr[RD_MSB:RD_LSB];
    d.ra     = instr[RA_MSB:RA_LSB];
    d.rb     = instr[RB_MSB:RB_LSB];
    d.offset = {{(DATA_WIDTH-OFF_WIDTH){instr[OFF_MSB]}}, instr[OFF_MSB:OFF_LSB]};
    d.pc     = pc;
    case (d.opcode)
      OP_ADD, OP_SUB, OP_MUL: begin d.uses_ra = 1'b1; d.uses_rb = 1'b1; d.writes_rd = 1'b1; d.legal = 1'b1; end
      OP_LDB, OP_LDW:         begin d.uses_ra = 1'b1; d.writes_rd = 1'b1; d.legal = 1'b1; end
      OP_STB, OP_STW, OP_BEQ: begin d.uses_ra = 1'b1; d.uses_rb = 1'b1; d.legal = 1'b1; end
      OP_JUMP:                begin d.uses_ra = 1'b1; d.legal = 1'b1; end
      default:                d.legal = 1'b0;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/decode_if.sv
// Fetch / writeback / ALU-side signal bundle of the decode stage.
interface decode_if;
  import core_pkg::*;
  logic                      decode_instr_valid;
  logic [INSTR_WIDTH-1:0]    decode_instr_data;
  logic [PC_WIDTH-1:0]       decode_instr_pc;
  logic                      stall_fetch;
  logic                      stall_decode;
  logic                      flush;
  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_dest;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      alu_instr_valid;
  logic [OPCODE_WIDTH-1:0]   alu_opcode;
  logic [REG_ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0]     alu_ra_data;
  logic [DATA_WIDTH-1:0]     alu_rb_data;
  logic [DATA_WIDTH-1:0]     alu_offset;
  logic [PC_WIDTH-1:0]       alu_pc;
  logic                      decode_illegal;

  modport slave (
    input  decode_instr_valid, decode_instr_data, decode_instr_pc,
    input  stall_decode, flush, wb_valid, wb_dest, wb_data,
    output stall_fetch, alu_instr_valid, alu_opcode, alu_rd, alu_ra_data,
    output alu_rb_data, alu_offset, alu_pc, decode_illegal
  );

  modport master (
    output decode_instr_valid, decode_instr_data, decode_instr_pc,
    output stall_decode, flush, wb_valid, wb_dest, wb_data,
    input  stall_fetch, alu_instr_valid, alu_opcode, alu_rd, alu_ra_data,
    input  alu_rb_data, alu_offset, alu_pc, decode_illegal
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with
// same-cycle bypass from the single write port.
module reg_file
  import core_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] ra_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rb_addr,
  output logic [DATA_WIDTH-1:0]     ra_data,
  output logic [DATA_WIDTH-1:0]     rb_data,
  input  logic                      wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]     wr_data
);
  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs;

  for (genvar i = 0; i < REG_NUM; i++) begin : g_reg
    always_ff @(posedge clock or posedge reset)
      if (reset)                                            regs[i] <= '0;
      else if (wr_en && wr_addr == REG_ADDR_WIDTH'(i))      regs[i] <= wr_data;
  end

  assign ra_data = (wr_en && wr_addr == ra_addr) ? wr_data : regs[ra_addr];
  assign rb_data = (wr_en && wr_addr == rb_addr) ? wr_data : regs[rb_addr];
endmodule

// File: rtl/decode_top.sv
// Decode stage: field crack, one-entry skid buffer, scoreboard hazard check,
// register read with writeback bypass and registered ALU-side outputs.
module decode_top
  import core_pkg::*;
(
  input logic    clock,
  input logic    reset,
  decode_if.slave bus
);
  logic                   skid_vld;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]    skid_pc;
  logic                   src_valid;
  logic [INSTR_WIDTH-1:0] src_instr;
  logic [PC_WIDTH-1:0]    src_pc;
  decoded_instr_t         dec;
  logic [REG_NUM-1:0]     pending, wb_clear, pend_eff, rd_set;
  logic                   hazard, advance;
  logic [DATA_WIDTH-1:0]  ra_rd, rb_rd;

  logic                      out_valid, out_illegal;
  logic [OPCODE_WIDTH-1:0]   out_opcode;
  logic [REG_ADDR_WIDTH-1:0] out_rd;
  logic [DATA_WIDTH-1:0]     out_ra, out_rb, out_offset;
  logic [PC_WIDTH-1:0]       out_pc;

  always_comb begin
    src_valid = skid_vld | bus.decode_instr_valid;
    src_instr = skid_vld ? skid_instr : bus.decode_instr_data;
    src_pc    = skid_vld ? skid_pc    : bus.decode_instr_pc;
  end

  assign dec = decode_instr(src_instr, src_pc);

  // A writeback landing this cycle releases its register for the same-cycle issue.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      wb_clear[i] = bus.wb_valid && (bus.wb_dest == REG_ADDR_WIDTH'(i));
      rd_set[i]   = advance && dec.writes_rd && (dec.rd == REG_ADDR_WIDTH'(i));
    end
    pend_eff = pending & ~wb_clear;
  end

  assign hazard  = (dec.uses_ra   & pend_eff[dec.ra]) |
                   (dec.uses_rb   & pend_eff[dec.rb]) |
                   (dec.writes_rd & pend_eff[dec.rd]);
  assign advance = src_valid & ~hazard & ~bus.stall_decode & ~bus.flush;

  assign bus.stall_fetch = skid_vld | (bus.decode_instr_valid & ~advance);

  reg_file u_rf (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (dec.ra),
    .rb_addr (dec.rb),
    .ra_data (ra_rd),
    .rb_data (rb_rd),
    .wr_en   (bus.wb_valid),
    .wr_addr (bus.wb_dest),
    .wr_data (bus.wb_data)
  );

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      skid_vld   <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (bus.flush) begin
      skid_vld <= 1'b0;
    end else if (skid_vld) begin
      if (advance) skid_vld <= 1'b0;
    end else if (bus.decode_instr_valid && !advance) begin
      skid_vld   <= 1'b1;
      skid_instr <= bus.decode_instr_data;
      skid_pc    <= bus.decode_instr_pc;
    end

  // Set beats clear so a same-cycle reissue to a retiring rd stays tracked.
  always_ff @(posedge clock or posedge reset)
    if (reset)          pending <= '0;
    else if (bus.flush) pending <= '0;
    else                pending <= (pending & ~wb_clear) | rd_set;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
      out_opcode  <= '0;
      out_rd      <= '0;
      out_ra      <= '0;
      out_rb      <= '0;
      out_offset  <= '0;
      out_pc      <= '0;
    end else if (bus.flush) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (advance) begin
      out_valid   <= dec.legal;
      out_illegal <= ~dec.legal;
      if (dec.legal) begin
        out_opcode <= dec.opcode;
        out_rd     <= dec.rd;
        out_ra     <= ra_rd;
        out_rb     <= rb_rd;
        out_offset <= dec.offset;
        out_pc     <= dec.pc;
      end
    end else if (!bus.stall_decode) begin
      out_valid   <= 1'b0;
      out_illegal <= 1'b0;
    end

  assign bus.alu_instr_valid = out_valid;
  assign bus.decode_illegal  = out_illegal;
  assign bus.alu_opcode      = out_opcode;
  assign bus.alu_rd          = out_rd;
  assign bus.alu_ra_data     = out_ra;
  assign bus.alu_rb_data     = out_rb;
  assign bus.alu_offset      = out_offset;
  assign bus.alu_pc          = out_pc;
endmodule

// File: tb/tb_decode_top.sv
// Directed bench for decode_top: an in-order issue model (architectural
// register values plus a queue of accepted instructions) checked every cycle.
module tb_decode_top;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  decode_if bus();
  decode_top dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, ra, rb;
    logic [31:0] off, pc;
    bit          ill;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mreg [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {7'h00, 7'h01, 7'h02, 7'h10, 7'h11, 7'h12, 7'h13, 7'h30, 7'h31};
  endfunction

  task automatic tick();
    @(negedge clock);
    bus.decode_instr_valid = 1'b0;
    bus.wb_valid           = 1'b0;
    bus.flush              = 1'b0;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    bus.decode_instr_valid = 1'b1;
    bus.decode_instr_data  = ins;
    bus.decode_instr_pc    = pc;
    e.op  = ins[31:25];
    e.rd  = ins[24:20];
    e.ra  = ins[19:15];
    e.rb  = ins[14:10];
    e.off = {{17{ins[14]}}, ins[14:0]};
    e.pc  = pc;
    e.ill = !legal_op(ins[31:25]);
    q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] v);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = d;
    bus.wb_data  = v;
  endtask

  // Every edge: issued instructions must leave in program order with register
  // values as of that edge (including its writeback); stalled outputs hold.
  initial begin : cmp
    logic        sd, fl, wv;
    logic [4:0]  wd;
    logic [31:0] wdat;
    logic        p_v, p_ill;
    logic [6:0]  p_op;
    logic [4:0]  p_rd;
    logic [31:0] p_ra, p_rb, p_off, p_pc;
    exp_t        e;
    p_v = 0; p_ill = 0; p_op = 0; p_rd = 0; p_ra = 0; p_rb = 0; p_off = 0; p_pc = 0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    forever begin
      @(posedge clock);
      sd = bus.stall_decode; fl = bus.flush; wv = bus.wb_valid;
      wd = bus.wb_dest; wdat = bus.wb_data;
      #1;
      if (reset) begin
        q.delete();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
      end else begin
        if (wv) mreg[wd] = wdat;
        if (fl) begin
          chk("flush_valid",   32'(bus.alu_instr_valid), 32'd0);
          chk("flush_illegal", 32'(bus.decode_illegal),  32'd0);
          q.delete();
        end else if (sd) begin
          chk("hold_valid",   32'(bus.alu_instr_valid), 32'(p_v));
          chk("hold_illegal", 32'(bus.decode_illegal),  32'(p_ill));
          chk("hold_opcode",  32'(bus.alu_opcode),      32'(p_op));
          chk("hold_rd",      32'(bus.alu_rd),          32'(p_rd));
          chk("hold_ra",      bus.alu_ra_data,          p_ra);
          chk("hold_rb",      bus.alu_rb_data,          p_rb);
          chk("hold_offset",  bus.alu_offset,           p_off);
          chk("hold_pc",      bus.alu_pc,               p_pc);
        end else if (bus.alu_instr_valid || bus.decode_illegal) begin
          if (q.size() == 0) begin
            chk("unexpected_issue", 32'(bus.alu_instr_valid | bus.decode_illegal), 32'd0);
          end else begin
            e = q.pop_front();
            if (e.ill) begin
              chk("illegal_pulse", 32'(bus.decode_illegal),  32'd1);
              chk("illegal_valid", 32'(bus.alu_instr_valid), 32'd0);
            end else begin
              chk("issue_valid",   32'(bus.alu_instr_valid), 32'd1);
              chk("issue_illegal", 32'(bus.decode_illegal),  32'd0);
              chk("issue_opcode",  32'(bus.alu_opcode),      32'(e.op));
              chk("issue_rd",      32'(bus.alu_rd),          32'(e.rd));
              chk("issue_ra",      bus.alu_ra_data,          mreg[e.ra]);
              chk("issue_rb",      bus.alu_rb_data,          mreg[e.rb]);
              chk("issue_offset",  bus.alu_offset,           e.off);
              chk("issue_pc",      bus.alu_pc,               e.pc);
            end
          end
        end
      end
      p_v = bus.alu_instr_valid; p_ill = bus.decode_illegal; p_op = bus.alu_opcode;
      p_rd = bus.alu_rd; p_ra = bus.alu_ra_data; p_rb = bus.alu_rb_data;
      p_off = bus.alu_offset; p_pc = bus.alu_pc;
    end
  end

  initial begin : stim
    bus.decode_instr_valid = 0; bus.decode_instr_data = 0; bus.decode_instr_pc = 0;
    bus.stall_decode = 0; bus.flush = 0; bus.wb_valid = 0; bus.wb_dest = 0; bus.wb_data = 0;
    repeat (2) @(negedge clock);
    chk("rst_valid",   32'(bus.alu_instr_valid), 32'd0);
    chk("rst_illegal", 32'(bus.decode_illegal),  32'd0);
    chk("rst_ra",      bus.alu_ra_data,          32'd0);
    chk("rst_offset",  bus.alu_offset,           32'd0);
    chk("rst_stall",   32'(bus.stall_fetch),     32'd0);
    chk("rst_sb",      dut.pending,              32'd0);
    reset = 1'b0;

    // ADD r3 = r1 + r2 with r2 arriving via bypass
    tick; wb(1, 32'd5);
    tick; wb(2, 32'd7); present(32'h00308800, 32'h100);
    tick;
    chk("add_valid", 32'(bus.alu_instr_valid), 32'd1);
    chk("add_ra",    bus.alu_ra_data,          32'd5);
    chk("add_rb",    bus.alu_rb_data,          32'd7);
    chk("add_rd",    32'(bus.alu_rd),          32'd3);
    chk("sb3_set",   32'(dut.pending[3]),      32'd1);

    // SUB r4 = r3 - r1: RAW stall until r3 writes back
    present(32'h02418400, 32'h104);
    #1 chk("raw_stall", 32'(bus.stall_fetch), 32'd1);
    tick;
    chk("raw_bubble", 32'(bus.alu_instr_valid), 32'd0);
    chk("raw_skid",   32'(bus.stall_fetch),     32'd1);
    tick; wb(3, 32'd12);
    tick;
    chk("sub_ra",     bus.alu_ra_data,     32'd12);
    chk("sub_rb",     bus.alu_rb_data,     32'd5);
    chk("sub_rd",     32'(bus.alu_rd),     32'd4);
    chk("sb4_set",    32'(dut.pending[4]), 32'd1);
    chk("sb3_clr",    32'(dut.pending[3]), 32'd0);
    chk("fetch_free", 32'(bus.stall_fetch), 32'd0);
    wb(4, 32'd7);
    tick;

    // stall_decode for 3 cycles with a second instruction arriving
    present(32'h00608800, 32'h108);
    tick; bus.stall_decode = 1'b1; present(32'h00710400, 32'h10C);
    tick;
    chk("stall_hold_rd", 32'(bus.alu_rd),      32'd6);
    chk("stall_fetch",   32'(bus.stall_fetch), 32'd1);
    tick; tick; bus.stall_decode = 1'b0;
    tick;
    chk("skid_rd", 32'(bus.alu_rd),  32'd7);
    chk("skid_ra", bus.alu_ra_data,  32'd7);
    chk("skid_pc", bus.alu_pc,       32'h10C);

    // back-to-back independent instructions: STW, BEQ, JUMP, MUL r8
    present(32'h26008800, 32'h110); tick;
    present(32'h60008400, 32'h114); tick;
    present(32'h62010000, 32'h118); tick;
    present(32'h04808800, 32'h11C); tick;
    chk("mul_opcode", 32'(bus.alu_opcode),  32'h02);
    chk("sb8_set",    32'(dut.pending[8]), 32'd1);

    // LDW r5 with negative offset
    present(32'h22587FFC, 32'h120); tick;
    chk("ldw_offset", bus.alu_offset,      32'hFFFFFFFC);
    chk("ldw_opcode", 32'(bus.alu_opcode), 32'h11);

    // illegal opcode 0x7F
    present(32'hFE000000, 32'h124); tick;
    chk("ill_pulse", 32'(bus.decode_illegal),  32'd1);
    chk("ill_valid", 32'(bus.alu_instr_valid), 32'd0);
    tick;
    chk("ill_end",   32'(bus.decode_illegal),  32'd0);

    // flush with skid occupied and r3 pending; writeback still lands
    present(32'h00308800, 32'h128); tick;
    present(32'h02418400, 32'h12C); tick;
    chk("pre_flush_skid", 32'(bus.stall_fetch), 32'd1);
    bus.flush = 1'b1; wb(9, 32'h99);
    tick;
    chk("flush_valid_lit", 32'(bus.alu_instr_valid), 32'd0);
    chk("flush_fetch",     32'(bus.stall_fetch),     32'd0);
    chk("flush_sb",        dut.pending,              32'd0);
    present(32'h00A4A400, 32'h130); tick;
    chk("post_flush_ra", bus.alu_ra_data, 32'h99);
    chk("post_flush_rd", 32'(bus.alu_rd), 32'd10);

    // asynchronous reset mid-operation
    present(32'h00C08800, 32'h134); tick;
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.alu_instr_valid), 32'd0);
    chk("arst_sb",    dut.pending,              32'd0);
    chk("arst_ra",    bus.alu_ra_data,          32'd0);
    tick; reset = 1'b0;
    tick; tick;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
